// File: rtl/pcm_pwm_player.sv
// PCM sample FIFO feeding a PWM audio generator. Each sample is held for
// PWM_REPEAT full PWM periods; playback starts once the FIFO reaches START_LEVEL.
module pcm_pwm_player #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int START_LEVEL = 8,
  parameter int PWM_REPEAT  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             pcmData,
  input  logic                          pcmValid,
  input  logic                          clrFlags,
  output logic                          ampPWM,
  output logic                          ampSD,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic                          overflow,
  output logic                          underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = (PWM_REPEAT > 1) ? $clog2(PWM_REPEAT) : 1;
  localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [DATA_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [RW-1:0]       rep_cnt_q, rep_cnt_d;
  logic [DATA_W-1:0]   cur_sample_q, cur_sample_d;
  logic                amp_pwm_q, amp_pwm_d;
  logic                overflow_q, overflow_d;
  logic                underrun_q, underrun_d;
  logic                pop, push_ok, ovf_evt, und_evt;

  always_comb begin
    state_d      = state_q;
    pwm_cnt_d    = pwm_cnt_q;
    rep_cnt_d    = rep_cnt_q;
    cur_sample_d = cur_sample_q;
    amp_pwm_d    = 1'b0;
    pop          = 1'b0;
    und_evt      = 1'b0;

    case (state_q)
      IDLE: begin
        pwm_cnt_d = '0;
        rep_cnt_d = '0;
        if (level_q >= LW'(START_LEVEL)) begin
          pop          = 1'b1;
          cur_sample_d = mem_q[rd_ptr_q];
          state_d      = PLAY;
        end
      end
      PLAY: begin
        amp_pwm_d = (pwm_cnt_q < cur_sample_q);
        pwm_cnt_d = pwm_cnt_q + DATA_W'(1);
        if (pwm_cnt_q == '1) begin
          if (rep_cnt_q == RW'(PWM_REPEAT - 1)) begin
            rep_cnt_d = '0;
            if (level_q != '0) begin
              pop          = 1'b1;
              cur_sample_d = mem_q[rd_ptr_q];
            end else begin
              und_evt      = 1'b1;
              cur_sample_d = MID;
              state_d      = IDLE;
            end
          end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push_ok  = pcmValid && ((level_q != LW'(FIFO_DEPTH)) || pop);
    ovf_evt  = pcmValid && !push_ok;
    level_d  = level_q + LW'(push_ok) - LW'(pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;

    overflow_d = (overflow_q && !clrFlags) || ovf_evt;
    underrun_d = (underrun_q && !clrFlags) || und_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pwm_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      cur_sample_q <= MID;
      amp_pwm_q    <= 1'b0;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pwm_cnt_q    <= pwm_cnt_d;
      rep_cnt_q    <= rep_cnt_d;
      cur_sample_q <= cur_sample_d;
      amp_pwm_q    <= amp_pwm_d;
      overflow_q   <= overflow_d;
      underrun_q   <= underrun_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= pcmData;
  end

  assign ampPWM    = amp_pwm_q;
  assign ampSD     = (state_q == PLAY);
  assign fifoLevel = level_q;
  assign overflow  = overflow_q;
  assign underrun  = underrun_q;
endmodule

// File: tb/tb_pcm_pwm_player.sv
// Directed + random bench for pcm_pwm_player against a queue-based playback model.
module tb_pcm_pwm_player;
  localparam int DW = 4, DEPTH = 4, START = 2, REP = 2;
  localparam int P = 1 << DW, MID = 1 << (DW - 1);

  logic          clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] pcmData = '0;
  logic          pcmValid = 1'b0, clrFlags = 1'b0;
  logic          ampPWM, ampSD, overflow, underrun;
  logic [2:0]    fifoLevel;

  pcm_pwm_player #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .START_LEVEL(START), .PWM_REPEAT(REP)) dut (
    .clk(clk), .reset(reset), .pcmData(pcmData), .pcmValid(pcmValid), .clrFlags(clrFlags),
    .ampPWM(ampPWM), .ampSD(ampSD), .fifoLevel(fifoLevel), .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // Model: queue of pending samples, playing flag, clocks into the current sample.
  int mq[$];
  int m_play = 0, m_tick = 0, m_cur = MID, m_amp = 0, m_ovf = 0, m_und = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic v, input int d, input logic c, input logic r);
    int new_amp, ovf_e, und_e;
    if (r) begin
      mq.delete();
      m_play = 0; m_tick = 0; m_cur = MID; m_amp = 0; m_ovf = 0; m_und = 0;
      return;
    end
    ovf_e = 0; und_e = 0;
    new_amp = (m_play != 0 && (m_tick % P) < m_cur) ? 1 : 0;
    if (m_play != 0) begin
      if (m_tick == REP * P - 1) begin
        m_tick = 0;
        if (mq.size() > 0) m_cur = mq.pop_front();
        else begin und_e = 1; m_cur = MID; m_play = 0; end
      end else m_tick++;
    end else if (mq.size() >= START) begin
      m_cur = mq.pop_front(); m_play = 1; m_tick = 0;
    end
    if (v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else ovf_e = 1;
    end
    m_amp = new_amp;
    m_ovf = ((m_ovf != 0 && !c) || ovf_e != 0) ? 1 : 0;
    m_und = ((m_und != 0 && !c) || und_e != 0) ? 1 : 0;
  endtask

  task automatic step(input logic v, input int d, input logic c, input logic r);
    pcmValid = v; pcmData = DW'(d); clrFlags = c; reset = r;
    @(posedge clk);
    model_edge(v, d, c, r);
    #1;
    chk("ampPWM", 32'(ampPWM), 32'(m_amp));
    chk("ampSD", 32'(ampSD), 32'(m_play));
    chk("fifoLevel", 32'(fifoLevel), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underrun", 32'(underrun), 32'(m_und));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int n, highs;
    // 1: reset held with strobes present
    for (int i = 0; i < 5; i++) step(1'b1, int'($urandom_range(0, P - 1)), 1'b0, 1'b1);
    idle(2);
    chk("rst_level", 32'(fifoLevel), 0);
    chk("rst_sd", 32'(ampSD), 0);

    // 2 and 5: 5 then 3, drain to underrun, then clear
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("play_entered", 32'(ampSD), 1);
    step(1'b0, 0, 1'b0, 1'b0);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      highs += int'(ampPWM);
      step(1'b0, 0, 1'b0, 1'b0);
    end
    chk("duty_5", 32'(highs), 5);
    idle(2 * REP * P);
    chk("underrun_set", 32'(underrun), 1);
    chk("underrun_idle", 32'(ampSD), 0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("underrun_clr", 32'(underrun), 0);

    // 3: extremes 0 and 15
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b1, P - 1, 1'b0, 1'b0);
    idle(3 * REP * P + 4);
    step(1'b0, 0, 1'b1, 1'b0);

    // 4: six back-to-back pushes overflow the FIFO
    for (int i = 0; i < 6; i++) step(1'b1, i + 9, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(fifoLevel), DEPTH);
    idle(6 * REP * P);
    step(1'b0, 0, 1'b1, 1'b0);

    // 6: push into a full FIFO on the exact sample-boundary pop
    for (int i = 0; i < 5; i++) step(1'b1, i + 2, 1'b0, 1'b0);
    n = 0;
    while (!(m_play != 0 && m_tick == REP * P - 1 && mq.size() == DEPTH) && n < 200) begin
      step(1'b0, 0, 1'b0, 1'b0);
      n++;
    end
    chk("boundary_wait", 32'(n < 200), 1);
    step(1'b1, 11, 1'b0, 1'b0);
    chk("full_pushpop_level", 32'(fifoLevel), DEPTH);
    chk("full_pushpop_ovf", 32'(overflow), 0);
    idle(7);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("midrst_sd", 32'(ampSD), 0);
    chk("midrst_level", 32'(fifoLevel), 0);

    // Random traffic
    for (int i = 0; i < 900; i++)
      step(($urandom % 24) == 0, int'($urandom_range(0, P - 1)),
           ($urandom % 60) == 0, ($urandom % 400) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
